// File: rtl/led_bank_pwm_if.sv
// Write port of the LED bank: single-cycle strobe with a ready qualifier.
// The writer owns wr_en/wr_idx/wr_mode/wr_duty; the LED bank owns wr_ready.
interface led_bank_pwm_if #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PWM_BITS = 8
);
  localparam int unsigned IdxW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic                wr_en;
  logic [IdxW-1:0]     wr_idx;
  logic [1:0]          wr_mode;
  logic [PWM_BITS-1:0] wr_duty;
  logic                wr_ready;

  modport master (
    output wr_en,
    output wr_idx,
    output wr_mode,
    output wr_duty,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_idx,
    input  wr_mode,
    input  wr_duty,
    output wr_ready
  );
endinterface

// File: rtl/led_bank_pwm.sv
// Multi-channel LED driver with OFF/ON/PWM/BLINK modes per channel.
// Writes land in shadow registers and take effect only at PWM frame boundaries.
module led_bank_pwm #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  led_bank_pwm_if.slave       wr,
  output logic [NUM_LEDS-1:0] led,
  output logic                frame_pulse
);

  localparam int unsigned IdxW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModePwm   = 2'd2,
    ModeBlink = 2'd3
  } mode_e;

  logic [PreW-1:0]     r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [BlkW-1:0]     r_blink_cnt;
  logic                r_blink_phase;
  logic                r_frame_pulse;
  logic [NUM_LEDS-1:0] r_led;

  mode_e               r_sh_mode  [NUM_LEDS];
  logic [PWM_BITS-1:0] r_sh_duty  [NUM_LEDS];
  mode_e               r_act_mode [NUM_LEDS];
  logic [PWM_BITS-1:0] r_act_duty [NUM_LEDS];

  logic                w_tick;
  logic                w_frame_end;
  logic                w_wr_accept;
  logic [NUM_LEDS-1:0] w_led_d;

  assign w_tick      = (r_pre_cnt == PreW'(PRESCALE - 1));
  assign w_frame_end = w_tick && (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign w_wr_accept = wr.wr_en && wr.wr_ready;

  assign wr.wr_ready = ~w_frame_end;
  assign led         = r_led;
  assign frame_pulse = r_frame_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt     <= '0;
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_pulse <= 1'b0;
      r_led         <= '0;
    end else begin
      r_pre_cnt     <= w_tick ? '0 : r_pre_cnt + 1'b1;
      r_frame_pulse <= w_frame_end;
      r_led         <= w_led_d;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
      if (w_frame_end) begin
        if (r_blink_cnt == BlkW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  // Index compare per channel: indices >= NUM_LEDS match nothing and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_sh_mode[i]  <= ModeOff;
        r_sh_duty[i]  <= '0;
        r_act_mode[i] <= ModeOff;
        r_act_duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_wr_accept && (wr.wr_idx == IdxW'(i))) begin
          r_sh_mode[i] <= mode_e'(wr.wr_mode);
          r_sh_duty[i] <= wr.wr_duty;
        end
        if (w_frame_end) begin
          r_act_mode[i] <= r_sh_mode[i];
          r_act_duty[i] <= r_sh_duty[i];
        end
      end
    end
  end

  always_comb begin
    w_led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      unique case (r_act_mode[i])
        ModeOff:   w_led_d[i] = 1'b0;
        ModeOn:    w_led_d[i] = 1'b1;
        ModePwm:   w_led_d[i] = (r_pwm_cnt < r_act_duty[i]);
        ModeBlink: w_led_d[i] = r_blink_phase && (r_pwm_cnt < r_act_duty[i]);
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_pwm.sv
// Scoreboard bench for led_bank_pwm: expected per-frame LED waveforms are queued by the
// stimulus and checked by a monitor each time the DUT raises frame_pulse.
module tb_led_bank_pwm;

  // Five channels so that out-of-range indices (5, 7) are encodable in the 3-bit index.
  localparam int unsigned NL = 5;
  localparam int unsigned PB = 3;
  localparam int unsigned PS = 2;
  localparam int unsigned BF = 2;
  localparam int unsigned FrameCyc = 16;

  localparam logic [1:0] MOff   = 2'd0;
  localparam logic [1:0] MOn    = 2'd1;
  localparam logic [1:0] MPwm   = 2'd2;
  localparam logic [1:0] MBlink = 2'd3;

  // Waveforms over one frame, bit k = cycle k after frame_pulse (k=0 is the pulse cycle).
  localparam logic [15:0] WOff   = 16'h0000;
  localparam logic [15:0] WOnNew = 16'hFFFE;
  localparam logic [15:0] WOn    = 16'hFFFF;
  localparam logic [15:0] WDuty3 = 16'h007E;
  localparam logic [15:0] WDuty7 = 16'h7FFE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] led;
  logic          frame_pulse;

  led_bank_pwm_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) wr_if ();

  led_bank_pwm #(
    .NUM_LEDS    (NL),
    .PWM_BITS    (PB),
    .PRESCALE    (PS),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if),
    .led        (led),
    .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NL-1:0][15:0] exp_q [$];
  logic [NL-1:0][15:0] got_buf;
  logic [NL-1:0][15:0] exp_frame;
  int                  mon_cyc = 0;
  int                  mon_frame = 0;
  int                  cur = 0;

  task automatic push_frame(input logic [15:0] w4, input logic [15:0] w3,
                            input logic [15:0] w2, input logic [15:0] w1,
                            input logic [15:0] w0);
    logic [NL-1:0][15:0] f;
    f[4] = w4; f[3] = w3; f[2] = w2; f[1] = w1; f[0] = w0;
    exp_q.push_back(f);
  endtask

  task automatic wait_to(input int n);
    while (cur < n) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  task automatic do_write(input int at, input int idx, input logic [1:0] mode, input int duty);
    wait_to(at);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_idx  = 3'(idx);
    wr_if.wr_mode = mode;
    wr_if.wr_duty = 3'(duty);
    @(posedge clk);
    #1;
    cur++;
    wr_if.wr_en = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // Monitor: per-cycle frame_pulse / wr_ready timing, and per-frame waveform compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cyc = 0;
    end else begin
      check_bit($sformatf("frame_pulse cyc%0d", mon_cyc), frame_pulse,
                (mon_cyc % FrameCyc == 0) && (mon_cyc > 0));
      check_bit($sformatf("wr_ready cyc%0d", mon_cyc), wr_if.wr_ready,
                (mon_cyc % FrameCyc) != FrameCyc - 1);
      if (frame_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard underflow at cyc%0d: got frame_pulse expected none", mon_cyc);
        end else begin
          exp_frame = exp_q.pop_front();
          for (int ch = 0; ch < NL; ch++) begin
            checks++;
            if (got_buf[ch] !== exp_frame[ch]) begin
              errors++;
              $display("FAIL frame%0d ch%0d waveform: got %h expected %h",
                       mon_frame, ch, got_buf[ch], exp_frame[ch]);
            end
          end
          mon_frame++;
        end
      end
      for (int ch = 0; ch < NL; ch++) begin
        got_buf[ch][mon_cyc % FrameCyc] = led[ch];
      end
      mon_cyc++;
    end
  end

  initial begin
    wr_if.wr_en   = 1'b0;
    wr_if.wr_idx  = '0;
    wr_if.wr_mode = '0;
    wr_if.wr_duty = '0;
    got_buf       = '0;

    // Frames 0..9 after the first release (ch4, ch3, ch2, ch1, ch0).
    push_frame(WOff, WOff, WOff,   WOff,   WOff);
    push_frame(WOff, WOff, WOff,   WOnNew, WDuty3);
    push_frame(WOff, WOff, WOff,   WOn,    WDuty3);
    push_frame(WOff, WOff, WOff,   WOn,    WOff);
    push_frame(WOff, WOff, WOff,   WOn,    WDuty7);
    push_frame(WOff, WOff, WOff,   WOn,    WDuty7);
    push_frame(WOff, WOff, WDuty7, WOn,    WDuty7);
    push_frame(WOff, WOff, WDuty7, WOn,    WDuty7);
    push_frame(WOff, WOff, WOff,   WOn,    WDuty7);
    push_frame(WOff, WOff, WOff,   WOn,    WDuty7);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur   = 0;

    do_write(3,  1, MOn,    0);
    do_write(5,  0, MPwm,   3);
    do_write(9,  5, MOn,    0);  // out of range
    do_write(10, 7, MOn,    0);  // out of range
    do_write(11, 3, MOn,    0);
    do_write(12, 3, MOff,   0);  // last write wins
    do_write(15, 4, MOn,    0);  // wr_ready low: dropped
    do_write(40, 0, MPwm,   0);
    do_write(50, 2, MBlink, 7);
    do_write(52, 0, MPwm,   7);

    wait_to(163);
    checks++;
    if (led !== 5'b00111) begin
      errors++;
      $display("FAIL led before reset: got %b expected %b", led, 5'b00111);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 5'b00000) begin
      errors++;
      $display("FAIL led async reset: got %b expected %b", led, 5'b00000);
    end
    check_bit("frame_pulse async reset", frame_pulse, 1'b0);
    check_bit("wr_ready in reset", wr_if.wr_ready, 1'b1);

    // After the second release: everything OFF until ch1 is rewritten in frame 1.
    push_frame(WOff, WOff, WOff, WOff,   WOff);
    push_frame(WOff, WOff, WOff, WOff,   WOff);
    push_frame(WOff, WOff, WOff, WOnNew, WOff);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur   = 0;

    do_write(20, 1, MOn, 0);
    wait_to(50);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d frames left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
